// File: rtl/tm1638_responder.sv
// TM1638 device-side model: receives commands/data on stb/sclk/dio into a
// 16-byte display RAM and display-control registers, and returns key-scan bytes.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stb,
    input  logic        sclk,
    inout  wire         dio,
    input  logic [31:0] key_data,
    input  logic [3:0]  ram_rd_addr,
    output logic [7:0]  ram_rd_data,
    output logic        display_on,
    output logic [2:0]  brightness,
    output logic        wr_strobe,
    output logic [3:0]  wr_addr,
    output logic        frame_err
);

    typedef enum logic [2:0] {IDLE, CMD, DATA, IGNORE, READ} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] stb_sync_q, sclk_sync_q, dio_sync_q;
    logic stb_prev_q, sclk_prev_q;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  sr_q, sr_d;
    logic [3:0]  addr_q, addr_d;
    logic        fixed_q, fixed_d;
    logic        read_mode_q, read_mode_d;
    logic        discard_q, discard_d;
    logic [31:0] key_sr_q, key_sr_d;
    logic [4:0]  read_cnt_q, read_cnt_d;
    logic        dio_oe_q, dio_oe_d;
    logic        disp_q, disp_d;
    logic [2:0]  bright_q, bright_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic        frame_err_q, frame_err_d;
    logic        ram_we;

    logic [7:0]  ram_q [16];
    logic [7:0]  ram_rd_data_q;

    logic stb_s, sclk_s, dio_s;
    logic stb_fall, stb_rise, sclk_fall, sclk_rise;
    logic [7:0] sr_next;

    assign stb_s     = stb_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign dio_s     = dio_sync_q[SYNC_STAGES-1];
    assign stb_fall  = stb_prev_q & ~stb_s;
    assign stb_rise  = ~stb_prev_q & stb_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    // LSB-first: the new bit enters at the top, the completed byte is sr_next.
    assign sr_next   = {dio_s, sr_q};

    // Open-drain style: only ever pull low, the board pull-up supplies a 1.
    assign dio = dio_oe_q ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stb_sync_q  <= '1;
            sclk_sync_q <= '1;
            dio_sync_q  <= '1;
            stb_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            addr_q      <= '0;
            fixed_q     <= 1'b0;
            read_mode_q <= 1'b0;
            discard_q   <= 1'b0;
            key_sr_q    <= '0;
            read_cnt_q  <= '0;
            dio_oe_q    <= 1'b0;
            disp_q      <= 1'b0;
            bright_q    <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            stb_sync_q  <= {stb_sync_q[SYNC_STAGES-2:0], stb};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            dio_sync_q  <= {dio_sync_q[SYNC_STAGES-2:0], dio};
            stb_prev_q  <= stb_s;
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            fixed_q     <= fixed_d;
            read_mode_q <= read_mode_d;
            discard_q   <= discard_d;
            key_sr_q    <= key_sr_d;
            read_cnt_q  <= read_cnt_d;
            dio_oe_q    <= dio_oe_d;
            disp_q      <= disp_d;
            bright_q    <= bright_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) ram_q[i] <= '0;
            ram_rd_data_q <= '0;
        end else begin
            if (ram_we) ram_q[addr_q] <= sr_next;
            ram_rd_data_q <= ram_q[ram_rd_addr];
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        addr_d      = addr_q;
        fixed_d     = fixed_q;
        read_mode_d = read_mode_q;
        discard_d   = discard_q;
        key_sr_d    = key_sr_q;
        read_cnt_d  = read_cnt_q;
        dio_oe_d    = dio_oe_q;
        disp_d      = disp_q;
        bright_d    = bright_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        ram_we      = 1'b0;

        // stb edges take priority over any sclk edge seen in the same cycle.
        if (stb_rise) begin
            state_d   = IDLE;
            dio_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if ((state_q == CMD || state_q == DATA) && bit_cnt_q != 3'd0)
                frame_err_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stb_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                        sr_d      = '0;
                    end
                end
                CMD, DATA: begin
                    if (sclk_rise) begin
                        sr_d      = sr_next[7:1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7 && state_q == CMD) begin
                            case (sr_next[7:6])
                                2'b01: begin
                                    read_mode_d = sr_next[1];
                                    fixed_d     = sr_next[2];
                                    if (sr_next[1]) begin
                                        key_sr_d   = key_data;
                                        read_cnt_d = '0;
                                        state_d    = READ;
                                    end else begin
                                        state_d = IGNORE;
                                    end
                                end
                                2'b11: begin
                                    addr_d    = sr_next[3:0];
                                    discard_d = read_mode_q;
                                    state_d   = DATA;
                                end
                                2'b10: begin
                                    disp_d   = sr_next[3];
                                    bright_d = sr_next[2:0];
                                    state_d  = IGNORE;
                                end
                                default: state_d = IGNORE;
                            endcase
                        end else if (bit_cnt_q == 3'd7 && !discard_q) begin
                            ram_we      = 1'b1;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            if (!fixed_q) addr_d = addr_q + 4'd1;
                        end
                    end
                end
                READ: begin
                    if (sclk_fall) begin
                        dio_oe_d = ~key_sr_q[read_cnt_q];
                    end else if (sclk_rise) begin
                        read_cnt_d = read_cnt_q + 5'd1;
                        if (read_cnt_q == 5'd31) begin
                            dio_oe_d = 1'b0;
                            state_d  = IGNORE;
                        end
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign ram_rd_data = ram_rd_data_q;
    assign display_on  = disp_q;
    assign brightness  = bright_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: acts as the controller on stb/sclk/dio and
// scores RAM writes, key-scan bytes and display-control state.
module tb_tm1638_responder;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stb = 1'b1;
    logic        sclk = 1'b1;
    logic        tb_oe = 1'b0;
    logic        tb_val = 1'b1;
    logic [31:0] key_data = 32'h0;
    logic [3:0]  ram_rd_addr = 4'h0;
    logic [7:0]  ram_rd_data;
    logic        display_on;
    logic [2:0]  brightness;
    logic        wr_strobe;
    logic [3:0]  wr_addr;
    logic        frame_err;
    wire         dio;

    pullup (dio);
    assign dio = tb_oe ? tb_val : 1'bz;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    logic [7:0] exp_ram [16];
    logic [3:0] exp_wr_q [$];
    logic [7:0] exp_key_q [$];

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .stb(stb), .sclk(sclk), .dio(dio),
        .key_data(key_data), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .display_on(display_on), .brightness(brightness), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sclk   = 1'b0;
            tb_oe  = 1'b1;
            tb_val = b[i];
            wait_clks(HALF);
            sclk = 1'b1;
            wait_clks(HALF);
        end
    endtask

    task automatic stb_low();
        stb = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic stb_high();
        stb   = 1'b1;
        tb_oe = 1'b0;
        wait_clks(2 * HALF);
    endtask

    task automatic frame1(input logic [7:0] b0);
        stb_low();
        send_bits(b0, 8);
        stb_high();
    endtask

    task automatic frame3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        stb_low();
        send_bits(b0, 8);
        send_bits(b1, 8);
        send_bits(b2, 8);
        stb_high();
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 16; i++) begin
            ram_rd_addr = 4'(i);
            wait_clks(1);
            chk($sformatf("%s[%0d]", tag, i), {24'h0, ram_rd_data}, {24'h0, exp_ram[i]});
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (wr_strobe) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                else chk("wr_addr", {28'h0, wr_addr}, {28'h0, exp_wr_q.pop_front()});
            end
            if (frame_err) ferr_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;

        wait_clks(2);
        reset = 1'b1;
        wait_clks(4);
        chk("rst_display_on", {31'h0, display_on}, 32'd0);
        chk("rst_brightness", {29'h0, brightness}, 32'd0);
        chk("rst_wr_strobe", {31'h0, wr_strobe}, 32'd0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'd0);
        chk("rst_dio_z", {31'h0, dio}, 32'd1);
        check_ram("rst_ram");

        // auto-increment write at 0
        exp_wr_q.push_back(4'd0); exp_wr_q.push_back(4'd1); exp_wr_q.push_back(4'd2);
        exp_ram[0] = 8'h11; exp_ram[1] = 8'h22; exp_ram[2] = 8'h33;
        frame1(8'h40);
        stb_low();
        send_bits(8'hC0, 8); send_bits(8'h11, 8); send_bits(8'h22, 8); send_bits(8'h33, 8);
        stb_high();
        chk("auto_wr_pending", exp_wr_q.size(), 32'd0);
        check_ram("auto_ram");

        // fixed address at 15
        exp_wr_q.push_back(4'd15); exp_wr_q.push_back(4'd15);
        exp_ram[15] = 8'hBB;
        frame1(8'h44);
        frame3(8'hCF, 8'hAA, 8'hBB);
        chk("fixed_wr_pending", exp_wr_q.size(), 32'd0);
        check_ram("fixed_ram");

        // auto wrap 15 -> 0
        exp_wr_q.push_back(4'd15); exp_wr_q.push_back(4'd0);
        exp_ram[15] = 8'h01; exp_ram[0] = 8'h02;
        frame1(8'h40);
        frame3(8'hCF, 8'h01, 8'h02);
        chk("wrap_wr_pending", exp_wr_q.size(), 32'd0);
        check_ram("wrap_ram");

        frame1(8'h8C);
        chk("dc_on", {31'h0, display_on}, 32'd1);
        chk("dc_bright4", {29'h0, brightness}, 32'd4);
        frame1(8'h80);
        chk("dc_off", {31'h0, display_on}, 32'd0);
        chk("dc_bright0", {29'h0, brightness}, 32'd0);

        // key read
        key_data = 32'hA53C0F81;
        exp_key_q.push_back(8'h81); exp_key_q.push_back(8'h0F);
        exp_key_q.push_back(8'h3C); exp_key_q.push_back(8'hA5);
        stb_low();
        send_bits(8'h42, 8);
        tb_oe = 1'b0;
        rx = 8'h00;
        for (int i = 0; i < 32; i++) begin
            sclk = 1'b0;
            wait_clks(HALF);
            rx = {dio, rx[7:1]};
            sclk = 1'b1;
            wait_clks(HALF);
            if (i % 8 == 7) chk($sformatf("key_byte%0d", i / 8), {24'h0, rx}, {24'h0, exp_key_q.pop_front()});
        end
        sclk = 1'b0;
        wait_clks(HALF);
        chk("dio_z_after32", {31'h0, dio}, 32'd1);
        sclk = 1'b1;
        wait_clks(HALF);
        stb_high();
        chk("dio_z_after_stb", {31'h0, dio}, 32'd1);

        // read mode still active: data bytes after address command are dropped
        stb_low();
        send_bits(8'hC0, 8); send_bits(8'h55, 8);
        stb_high();
        frame1(8'h40);
        check_ram("discard_ram");

        // partial byte abort
        stb_low();
        send_bits(8'hC3, 5);
        stb_high();
        chk("abort_ferr_pulses", ferr_cnt, 32'd1);
        check_ram("abort_ram");
        frame1(8'h8F);
        chk("post_abort_on", {31'h0, display_on}, 32'd1);
        chk("post_abort_bright", {29'h0, brightness}, 32'd7);
        chk("final_ferr_pulses", ferr_cnt, 32'd1);
        chk("final_wr_pending", exp_wr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
- Synthesizable TM1638 device-side model: the slave end of the stb/sclk/dio link driven by tm1638_controller.
- Deserialises command and data bytes into a 16-byte display RAM and display-control registers.
- Serialises 4 key-scan bytes back on dio for read commands.
- Used as the bench/loopback partner for the controller and as an FPGA-side TM1638 emulator.

Parameters:
SYNC_STAGES, 2, synchroniser depth on stb/sclk/dio inputs (min 2)

Ports:
clk  input  1  system clock; sclk must be no faster than clk/8
reset  input  1  synchronous, active-low reset
stb  input  1  frame strobe from controller, active low
sclk  input  1  serial clock from controller, idles high
dio  inout  1  serial data; driven only during key read, else high-Z (pull-up at top level)
key_data  input  32  key scan bytes; byte0 = [7:0] … byte3 = [31:24]
ram_rd_addr  input  4  display RAM read address
ram_rd_data  output  8  display RAM read data, registered, 1-cycle latency
display_on  output  1  display control bit 3
brightness  output  3  display control bits 2:0
wr_strobe  output  1  1-cycle pulse per RAM byte written
wr_addr  output  4  address of the write flagged by wr_strobe
frame_err  output  1  1-cycle pulse when stb rises with a partial byte

Behaviour:
- Reset (reset=0 at posedge clk): all 16 RAM bytes = 0x00; display_on=0; brightness=0; mode = write/auto-increment; addr=0; dio=Z; wr_strobe=0; frame_err=0; ram_rd_data=0; state IDLE.
- Inputs pass through SYNC_STAGES flops; edges detected on synchronised signals; all actions occur 1 clk after the detected edge.
- States: IDLE, CMD, DATA, IGNORE, READ.
- IDLE: on stb fall -> CMD; clear bit_cnt and shift register.
- sclk rise in CMD/DATA: sr <= {dio, sr[7:1]} (LSB first); bit_cnt++. At 8 bits the byte is complete; bit_cnt returns to 0.
- Byte decode in CMD, by sr[7:6]:
  - 01 = data command. bit1 = read; bit2 = fixed address (else auto-increment). Mode persists across frames. If read: latch key_data into key_sr, read_cnt=0, -> READ. Else -> IGNORE.
  - 11 = address command. addr <= sr[3:0]; -> DATA.
  - 10 = display control. display_on <= sr[3]; brightness <= sr[2:0]; -> IGNORE.
  - 00 = -> IGNORE.
- DATA, each completed byte:
  - RAM[addr] <= sr; wr_strobe=1; wr_addr=addr.
  - Auto mode: addr++ with wrap 15 -> 0. Fixed mode: addr unchanged.
  - A read mode active at address command: bytes are discarded (no write).
- READ:
  - On each sclk fall, dio drives key_sr[read_cnt]: 0 -> drive low, 1 -> Z.
  - On each sclk rise, read_cnt++.
  - The first fall after the command's 8th rise presents bit 0.
  - At read_cnt=32: dio=Z, -> IGNORE.
- IGNORE: all sclk edges ignored until stb rises.
- stb rise in any state: -> IDLE, dio=Z, bit_cnt=0. If the state was CMD/DATA with bit_cnt≠0: frame_err pulse, partial byte discarded.
- sclk/dio activity while stb high: no effect.
- stb fall and sclk edge in the same clk: stb handled first, and that sclk edge is ignored.
- reset asserted mid-frame: immediate return to reset values; the frame is abandoned.
- RAM read port is independent of the serial side. A write and a read to the same address in one clk return the old data.

Test Plan:
- Reset -> reset=0 for 2 clks -> display_on=0, brightness=0, ram_rd_data=0x00 for all 16 addresses, dio=Z.
- Auto write -> frames [0x40], [0xC0,0x11,0x22,0x33] -> RAM[0..2]=0x11,0x22,0x33, three wr_strobe pulses with wr_addr 0,1,2.
- Fixed mode and wrap:
  - [0x44], [0xCF,0xAA,0xBB] -> RAM[15]=0xBB, RAM[0] unchanged.
  - Then [0x40], [0xCF,0x01,0x02] -> RAM[15]=0x01, RAM[0]=0x02.
- Display control -> [0x8C] -> display_on=1, brightness=4. Then [0x80] -> display_on=0, brightness=0.
- Key read -> key_data=0xA53C0F81, frame [0x42] + 32 sclk -> controller samples 0x81,0x0F,0x3C,0xA5 LSB first; dio=Z after the 32nd bit and after stb rise.
- Aborted byte -> stb rises after 5 bits of 0xC3 -> frame_err 1-clk pulse, addr/RAM unchanged; next frame [0x8F] -> display_on=1, brightness=7.
